// File: rtl/mem_bus_if_if.sv
// System bus seen by the memory-stage master: request/grant arbitration plus
// address-strobe/ready data transfer.
interface mem_bus_if_if;
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned DATA_W      = 32;

  logic                   BusReq_;
  logic                   BusGrnt_;
  logic [WORD_ADDR_W-1:0] BusAddr;
  logic                   BusAS_;
  logic                   BusRW;
  logic [DATA_W-1:0]      BusWrData;
  logic [DATA_W-1:0]      BusRdData;
  logic                   BusRdy_;

  modport master (
    output BusReq_, BusAddr, BusAS_, BusRW, BusWrData,
    input  BusGrnt_, BusRdData, BusRdy_
  );

  modport slave (
    input  BusReq_, BusAddr, BusAS_, BusRW, BusWrData,
    output BusGrnt_, BusRdData, BusRdy_
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory-stage bus master: alignment check, request/grant/strobe/ready bus
// handshake, and the result/stall signals consumed by the EX/MEM register.
module mem_bus_if (
  input  logic                clk,
  input  logic                reset_,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [1:0]          MemOp,
  input  logic [31:0]         Addr,
  input  logic [31:0]         WrData,
  output logic [31:0]         Out,
  output logic                MissAlign,
  output logic                Busy,
  mem_bus_if_if.master        bus
);
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] MEM_OP_LDW = 2'd1;
  localparam logic [1:0] MEM_OP_STW = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   rd_buf;

  logic is_mem_op;
  logic valid_op;
  logic aligned;
  logic rdy;

  assign is_mem_op = (MemOp == MEM_OP_LDW) || (MemOp == MEM_OP_STW);
  assign valid_op  = is_mem_op && !Flush;
  assign aligned   = (Addr[1:0] == 2'b00);
  assign rdy       = !bus.BusRdy_;

  // State and registered bus outputs; bus fields latch on grant.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= IDLE;
      bus.BusReq_   <= 1'b1;
      bus.BusAS_    <= 1'b1;
      bus.BusAddr   <= '0;
      bus.BusRW     <= 1'b1;
      bus.BusWrData <= '0;
      rd_buf        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_op && aligned) begin
            state       <= REQ;
            bus.BusReq_ <= 1'b0;
          end
        end
        REQ: begin
          if (Flush) begin
            state       <= IDLE;
            bus.BusReq_ <= 1'b1;
          end else if (!bus.BusGrnt_) begin
            state         <= ACCESS;
            bus.BusAS_    <= 1'b0;
            bus.BusAddr   <= Addr[31:2];
            bus.BusRW     <= (MemOp == MEM_OP_LDW);
            bus.BusWrData <= WrData;
          end
        end
        ACCESS: begin
          // Strobe covers only the first access cycle.
          bus.BusAS_ <= 1'b1;
          if (rdy) begin
            rd_buf      <= bus.BusRW ? bus.BusRdData : DATA_W'(0);
            bus.BusReq_ <= 1'b1;
            // A flushed completion is dropped, so there is nothing to hold.
            state       <= (Stall && !Flush) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!Stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result mux, alignment flag and stall request.
  always_comb begin
    Out       = '0;
    MissAlign = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        MissAlign = valid_op && !aligned;
        Busy      = valid_op && aligned;
        if (!is_mem_op && !Flush) begin
          Out = Addr;
        end
      end
      REQ: begin
        Busy = 1'b1;
      end
      ACCESS: begin
        Busy = bus.BusRdy_;
        if (rdy && !Flush && bus.BusRW) begin
          Out = bus.BusRdData;
        end
      end
      HOLD: begin
        Out = rd_buf;
      end
      default: begin
        Out = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: per-cycle vector table plus hand-written
// reset-during-access sequence.
module tb_mem_bus_if;
  logic        clk;
  logic        reset_;
  logic        Stall;
  logic        Flush;
  logic [1:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] Out;
  logic        MissAlign;
  logic        Busy;

  mem_bus_if_if bus_i ();

  mem_bus_if dut (
    .clk       (clk),
    .reset_    (reset_),
    .Stall     (Stall),
    .Flush     (Flush),
    .MemOp     (MemOp),
    .Addr      (Addr),
    .WrData    (WrData),
    .Out       (Out),
    .MissAlign (MissAlign),
    .Busy      (Busy),
    .bus       (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  memop;
    logic        flush;
    logic        stall;
    logic        grnt_;
    logic        rdy_;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic [31:0] e_out;
    logic        e_miss;
    logic        e_busy;
    logic        e_req_;
    logic        e_as_;
    logic        e_rw;
    logic [29:0] e_baddr;
    logic [31:0] e_wdata;
  } vec_t;

  localparam int NVEC = 34;
  localparam logic [31:0] A5 = 32'hA5A5_A5A5;

  vec_t vecs [NVEC];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic [1:0] memop, input logic flush, input logic stall,
    input logic grnt_, input logic rdy_, input logic [31:0] addr,
    input logic [31:0] wrdata, input logic [31:0] rddata,
    input logic [31:0] e_out, input logic e_miss, input logic e_busy,
    input logic e_req_, input logic e_as_, input logic e_rw,
    input logic [29:0] e_baddr, input logic [31:0] e_wdata);
    vec_t v;
    v = '{memop, flush, stall, grnt_, rdy_, addr, wrdata, rddata,
          e_out, e_miss, e_busy, e_req_, e_as_, e_rw, e_baddr, e_wdata};
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    MemOp           = v.memop;
    Flush           = v.flush;
    Stall           = v.stall;
    Addr            = v.addr;
    WrData          = v.wrdata;
    bus_i.BusGrnt_  = v.grnt_;
    bus_i.BusRdy_   = v.rdy_;
    bus_i.BusRdData = v.rddata;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("Out",       idx, Out,                    v.e_out);
    chk("MissAlign", idx, 32'(MissAlign),         32'(v.e_miss));
    chk("Busy",      idx, 32'(Busy),              32'(v.e_busy));
    chk("BusReq_",   idx, 32'(bus_i.BusReq_),     32'(v.e_req_));
    chk("BusAS_",    idx, 32'(bus_i.BusAS_),      32'(v.e_as_));
    chk("BusRW",     idx, 32'(bus_i.BusRW),       32'(v.e_rw));
    chk("BusAddr",   idx, 32'(bus_i.BusAddr),     32'(v.e_baddr));
    chk("BusWrData", idx, bus_i.BusWrData,        v.e_wdata);
  endtask

  initial begin
    // NOP pass-through
    vecs[0]  = mk(2'd0,0,0,1,1,32'h1234_5678,0,0, 32'h1234_5678,0,0,1,1,1,30'h0,0);
    vecs[1]  = mk(2'd3,0,0,1,1,32'hCAFE_F00D,0,0, 32'hCAFE_F00D,0,0,1,1,1,30'h0,0);
    // aligned load: 2-cycle grant wait, 1-cycle ready wait
    vecs[2]  = mk(2'd1,0,0,1,1,32'h100,0,0, 0,0,1,1,1,1,30'h0,0);
    vecs[3]  = mk(2'd1,0,0,1,1,32'h100,0,0, 0,0,1,0,1,1,30'h0,0);
    vecs[4]  = mk(2'd1,0,0,1,1,32'h100,0,0, 0,0,1,0,1,1,30'h0,0);
    vecs[5]  = mk(2'd1,0,0,0,1,32'h100,0,0, 0,0,1,0,1,1,30'h0,0);
    vecs[6]  = mk(2'd1,0,0,1,1,32'h100,0,0, 0,0,1,0,0,1,30'h40,0);
    vecs[7]  = mk(2'd1,0,0,1,0,32'h100,0,32'hDEAD_BEEF, 32'hDEAD_BEEF,0,0,0,1,1,30'h40,0);
    vecs[8]  = mk(2'd0,0,0,1,1,32'h0,0,0, 0,0,0,1,1,1,30'h40,0);
    // misaligned store
    vecs[9]  = mk(2'd2,0,0,1,1,32'h102,0,0, 0,1,0,1,1,1,30'h40,0);
    vecs[10] = mk(2'd0,0,0,1,1,32'h55,0,0, 32'h55,0,0,1,1,1,30'h40,0);
    // store completing under stall, 3 HOLD cycles
    vecs[11] = mk(2'd2,0,0,0,1,32'h200,A5,0, 0,0,1,1,1,1,30'h40,0);
    vecs[12] = mk(2'd2,0,0,0,1,32'h200,A5,0, 0,0,1,0,1,1,30'h40,0);
    vecs[13] = mk(2'd2,0,1,1,0,32'h200,A5,32'h1111_1111, 0,0,0,0,0,0,30'h80,A5);
    vecs[14] = mk(2'd2,0,1,1,1,32'h200,A5,0, 0,0,0,1,1,0,30'h80,A5);
    vecs[15] = mk(2'd2,0,1,1,1,32'h200,A5,0, 0,0,0,1,1,0,30'h80,A5);
    vecs[16] = mk(2'd0,0,0,1,1,32'h777,0,0, 0,0,0,1,1,0,30'h80,A5);
    vecs[17] = mk(2'd0,0,0,1,1,32'h777,0,0, 32'h777,0,0,1,1,0,30'h80,A5);
    // load completing under stall: HOLD shows buffered data, ignores bus
    vecs[18] = mk(2'd1,0,0,0,1,32'h300,0,0, 0,0,1,1,1,0,30'h80,A5);
    vecs[19] = mk(2'd1,0,0,0,1,32'h300,0,0, 0,0,1,0,1,0,30'h80,A5);
    vecs[20] = mk(2'd1,0,1,1,0,32'h300,0,32'h1357_9BDF, 32'h1357_9BDF,0,0,0,0,1,30'hC0,0);
    vecs[21] = mk(2'd1,0,1,0,0,32'h300,0,32'hFFFF_FFFF, 32'h1357_9BDF,0,0,1,1,1,30'hC0,0);
    vecs[22] = mk(2'd0,0,0,1,1,32'h1,0,0, 32'h1357_9BDF,0,0,1,1,1,30'hC0,0);
    vecs[23] = mk(2'd0,0,0,1,1,32'h1,0,0, 32'h1,0,0,1,1,1,30'hC0,0);
    // flush in IDLE
    vecs[24] = mk(2'd1,1,0,1,1,32'h101,0,0, 0,0,0,1,1,1,30'hC0,0);
    vecs[25] = mk(2'd0,1,0,1,1,32'h44,0,0, 0,0,0,1,1,1,30'hC0,0);
    // flush in REQ beats a simultaneous grant
    vecs[26] = mk(2'd1,0,0,1,1,32'h400,0,0, 0,0,1,1,1,1,30'hC0,0);
    vecs[27] = mk(2'd1,1,0,0,1,32'h400,0,0, 0,0,1,0,1,1,30'hC0,0);
    vecs[28] = mk(2'd0,0,0,1,1,32'h9,0,0, 32'h9,0,0,1,1,1,30'hC0,0);
    // flush in ACCESS: transfer finishes, result discarded, no HOLD
    vecs[29] = mk(2'd1,0,0,0,1,32'h500,0,0, 0,0,1,1,1,1,30'hC0,0);
    vecs[30] = mk(2'd1,0,0,0,1,32'h500,0,0, 0,0,1,0,1,1,30'hC0,0);
    vecs[31] = mk(2'd1,1,0,1,1,32'h500,0,0, 0,0,1,0,0,1,30'h140,0);
    vecs[32] = mk(2'd1,1,1,1,0,32'h500,0,32'hBAD0_BAD0, 0,0,0,0,1,1,30'h140,0);
    vecs[33] = mk(2'd0,0,0,1,1,32'h2468,0,0, 32'h2468,0,0,1,1,1,30'h140,0);

    // reset state
    reset_ = 1'b0;
    drive(mk(2'd0,0,0,1,1,0,0,0, 0,0,0,1,1,1,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec(-1, mk(2'd0,0,0,1,1,0,0,0, 0,0,0,1,1,1,30'h0,0));
    @(posedge clk);
    #1 reset_ = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // reset pulsed during ACCESS releases the bus immediately
    drive(mk(2'd1,0,0,0,1,32'h600,32'h5555_AAAA,0, 0,0,0,1,1,1,0,0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus_i.BusGrnt_ = 1'b1;
    @(negedge clk);
    chk("rst_pre_AS",    100, 32'(bus_i.BusAS_),   32'd0);
    chk("rst_pre_Addr",  100, 32'(bus_i.BusAddr),  32'h180);
    chk("rst_pre_WrDat", 100, bus_i.BusWrData,     32'h5555_AAAA);
    chk("rst_pre_Busy",  100, 32'(Busy),           32'd1);
    #2;
    reset_ = 1'b0;
    MemOp  = 2'd0;
    Addr   = 32'h0;
    #1;
    check_vec(101, mk(2'd0,0,0,1,1,0,0,0, 0,0,0,1,1,1,30'h0,0));
    @(posedge clk);
    #1 reset_ = 1'b1;
    Addr = 32'hABC;
    @(negedge clk);
    check_vec(102, mk(2'd0,0,0,1,1,0,0,0, 32'hABC,0,0,1,1,1,30'h0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
